// File: rtl/ym_bus_master.sv
// Host-side initiator for the YM3812 (OPL2) parallel bus: runs one register write
// (address pass, recovery wait, data pass, recovery wait) or one read at a time.
module ym_bus_master #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned HOLD_CYC  = 1,
    parameter int unsigned ADDR_WAIT = 32,
    parameter int unsigned DATA_WAIT = 192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rd,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       ym_cs_l,
    output logic       ym_a0,
    output logic       ym_wr_l,
    output logic       ym_rd_l,
    output logic [7:0] yd_out,
    output logic       yd_oe,
    input  logic [7:0] yd_in
);

    // The down-counter is loaded with (length - 1) on entry and the state ends at zero.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
    localparam logic [7:0] AWAIT_LD = 8'(ADDR_WAIT - 1);
    localparam logic [7:0] DWAIT_LD = 8'(DATA_WAIT - 1);

    typedef enum logic [3:0] {
        IDLE,
        W_SET,
        W_PUL,
        W_HLD,
        A_WAIT,
        D_WAIT,
        R_SET,
        R_PUL,
        R_HLD
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;
    logic [7:0] data_q, data_d;

    logic       cs_l_q, cs_l_d;
    logic       a0_q, a0_d;
    logic       wr_l_q, wr_l_d;
    logic       rd_l_q, rd_l_d;
    logic [7:0] yd_out_q, yd_out_d;
    logic       yd_oe_q, yd_oe_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       ready_q, ready_d;
    logic       busy_q, busy_d;

    logic       last;

    assign last = (cnt_q == 8'd0);

    // Pin values are computed from the *next* state and registered, so every
    // bus output comes straight from a flop.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d    = state_q;
        cnt_d      = last ? cnt_q : cnt_q - 8'd1;
        phase_d    = phase_q;
        data_d     = data_q;
        a0_d       = a0_q;
        yd_out_d   = yd_out_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    phase_d = 1'b0;
                    cnt_d   = SETUP_LD;
                    if (req_rd) begin
                        state_d = R_SET;
                        a0_d    = req_reg[0];
                    end else begin
                        state_d  = W_SET;
                        a0_d     = 1'b0;
                        yd_out_d = req_reg;
                        data_d   = req_data;
                    end
                end
            end
            W_SET: begin
                if (last) begin
                    state_d = W_PUL;
                    cnt_d   = PULSE_LD;
                end
            end
            W_PUL: begin
                if (last) begin
                    state_d = W_HLD;
                    cnt_d   = HOLD_LD;
                end
            end
            W_HLD: begin
                if (last) begin
                    state_d = phase_q ? D_WAIT : A_WAIT;
                    cnt_d   = phase_q ? DWAIT_LD : AWAIT_LD;
                end
            end
            A_WAIT: begin
                // Address recovery done: start the data pass on the data port.
                if (last) begin
                    state_d  = W_SET;
                    cnt_d    = SETUP_LD;
                    phase_d  = 1'b1;
                    a0_d     = 1'b1;
                    yd_out_d = data_q;
                end
            end
            D_WAIT: begin
                if (last) begin
                    state_d = IDLE;
                end
            end
            R_SET: begin
                if (last) begin
                    state_d = R_PUL;
                    cnt_d   = PULSE_LD;
                end
            end
            R_PUL: begin
                if (last) begin
                    state_d   = R_HLD;
                    cnt_d     = HOLD_LD;
                    rd_data_d = yd_in;
                end
            end
            R_HLD: begin
                if (last) begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        cs_l_d  = 1'b1;
        wr_l_d  = 1'b1;
        rd_l_d  = 1'b1;
        yd_oe_d = 1'b0;
        case (state_d)
            W_SET, W_HLD: begin
                cs_l_d  = 1'b0;
                yd_oe_d = 1'b1;
            end
            W_PUL: begin
                cs_l_d  = 1'b0;
                yd_oe_d = 1'b1;
                wr_l_d  = 1'b0;
            end
            R_SET, R_HLD: begin
                cs_l_d = 1'b0;
            end
            R_PUL: begin
                cs_l_d = 1'b0;
                rd_l_d = 1'b0;
            end
            default: ;
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = ~ready_d;
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            phase_q    <= 1'b0;
            data_q     <= 8'd0;
            cs_l_q     <= 1'b1;
            a0_q       <= 1'b0;
            wr_l_q     <= 1'b1;
            rd_l_q     <= 1'b1;
            yd_out_q   <= 8'd0;
            yd_oe_q    <= 1'b0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            data_q     <= data_d;
            cs_l_q     <= cs_l_d;
            a0_q       <= a0_d;
            wr_l_q     <= wr_l_d;
            rd_l_q     <= rd_l_d;
            yd_out_q   <= yd_out_d;
            yd_oe_q    <= yd_oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign ym_cs_l   = cs_l_q;
    assign ym_a0     = a0_q;
    assign ym_wr_l   = wr_l_q;
    assign ym_rd_l   = rd_l_q;
    assign yd_out    = yd_out_q;
    assign yd_oe     = yd_oe_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_ym_bus_master.sv
// Bench for ym_bus_master: table vectors, hand sequences, random traffic against a
// timeline model, and a bus-invariant monitor on both the default and the 1-cycle instance.
`timescale 1ns/1ps
module tb_ym_bus_master;

    localparam int S  = 1;
    localparam int P  = 4;
    localparam int H  = 1;
    localparam int AW = 32;
    localparam int DW = 192;

    typedef struct packed {
        logic       rd;
        logic [7:0] reg_idx;
        logic [7:0] data;
    } req_t;

    typedef struct packed {
        logic       cs_l;
        logic       a0;
        logic       wr_l;
        logic       rd_l;
        logic       yd_oe;
        logic [7:0] yd_out;
    } bus_t;

    typedef struct packed {
        req_t       req;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [8:0] busy;
        logic [7:0] exp_rd;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_valid, req_rd, req_ready, rd_valid, busy;
    logic [7:0] req_reg, req_data, rd_data, yd_out, yd_in;
    logic       ym_cs_l, ym_a0, ym_wr_l, ym_rd_l, yd_oe;
    logic [7:0] resp_lo, resp_hi;

    logic       f_valid, f_rd, f_ready, f_rd_valid, f_busy;
    logic [7:0] f_reg, f_data, f_rd_data, f_yd_out, f_yd_in;
    logic       f_cs_l, f_a0, f_wr_l, f_rd_l, f_yd_oe;

    // Test responder: answers only while the read strobe is low.
    assign yd_in   = !ym_rd_l ? (ym_a0 ? resp_hi : resp_lo) : 8'h00;
    assign f_yd_in = !f_rd_l ? (f_a0 ? 8'hC3 : 8'h3C) : 8'h00;

    ym_bus_master u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
        .req_reg(req_reg), .req_data(req_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .ym_cs_l(ym_cs_l), .ym_a0(ym_a0), .ym_wr_l(ym_wr_l), .ym_rd_l(ym_rd_l),
        .yd_out(yd_out), .yd_oe(yd_oe), .yd_in(yd_in)
    );

    ym_bus_master #(
        .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .ADDR_WAIT(1), .DATA_WAIT(1)
    ) u_fast (
        .clk(clk), .rst(rst),
        .req_valid(f_valid), .req_ready(f_ready), .req_rd(f_rd),
        .req_reg(f_reg), .req_data(f_data),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .busy(f_busy),
        .ym_cs_l(f_cs_l), .ym_a0(f_a0), .ym_wr_l(f_wr_l), .ym_rd_l(f_rd_l),
        .yd_out(f_yd_out), .yd_oe(f_yd_oe), .yd_in(f_yd_in)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: cycle k (1 = first cycle after accept) of a transaction.
    function automatic bus_t model_bus(req_t r, int k, int s, int p, int h, int aw);
        bus_t       b;
        int         t;
        int         pl;
        logic [7:0] v;
        pl = s + p + h;
        t  = k;
        b  = '{cs_l: 1'b1, a0: 1'b0, wr_l: 1'b1, rd_l: 1'b1, yd_oe: 1'b0, yd_out: 8'h00};
        if (r.rd) begin
            b.cs_l = 1'b0;
            b.a0   = r.reg_idx[0];
            b.rd_l = !(t > s && t <= s + p);
            return b;
        end
        if (t > pl + aw) begin
            t    = t - (pl + aw);
            b.a0 = 1'b1;
            v    = r.data;
        end else begin
            v = r.reg_idx;
        end
        if (t <= pl) begin
            b.cs_l   = 1'b0;
            b.yd_oe  = 1'b1;
            b.yd_out = v;
            b.wr_l   = !(t > s && t <= s + p);
        end
        return b;
    endfunction

    function automatic int busy_len(req_t r);
        return r.rd ? (S + P + H) : (2 * (S + P + H) + AW + DW);
    endfunction

    function automatic bus_t sample_bus();
        return '{cs_l: ym_cs_l, a0: ym_a0, wr_l: ym_wr_l, rd_l: ym_rd_l,
                 yd_oe: yd_oe, yd_out: (yd_oe ? yd_out : 8'h00)};
    endfunction

    // Called in a cycle where the DUT is idle; returns in the first idle cycle after.
    task automatic run_txn(input req_t r, input int exp_busy, input logic [7:0] exp_rd,
                           input bit chain, input req_t nxt, input string tag);
        bus_t exp_b;
        req_valid = 1'b1;
        req_rd    = r.rd;
        req_reg   = r.reg_idx;
        req_data  = r.data;
        check({tag, " ready_before"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        if (chain) begin
            req_rd   = nxt.rd;
            req_reg  = nxt.reg_idx;
            req_data = nxt.data;
        end else begin
            req_valid = 1'b0;
            req_rd    = 1'($urandom);
            req_reg   = 8'($urandom);
            req_data  = 8'($urandom);
        end
        for (int k = 1; k <= exp_busy; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            exp_b = model_bus(r, k, S, P, H, AW);
            check($sformatf("%s k=%0d", tag, k),
                  32'({sample_bus(), req_ready, busy}), 32'({exp_b, 2'b01}));
        end
        @(posedge clk); #1;
        check({tag, " ready_after"}, 32'({req_ready, busy, ym_cs_l}), 32'(3'b101));
        check({tag, " rd_valid"}, 32'(rd_valid), 32'(r.rd));
        if (r.rd) check({tag, " rd_data"}, 32'(rd_data), 32'(exp_rd));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle", 32'({req_ready, busy, ym_cs_l, ym_wr_l, ym_rd_l, yd_oe, rd_valid}),
                  32'(7'b1011100));
        end
    endtask

    // Invariant monitor for both instances.
    logic       m_prev_low, f_prev_low;
    logic [10:0] m_prev_snap, f_prev_snap;

    function automatic logic [3:0] inv_bits(logic cs_l, logic wr_l, logic rd_l, logic oe,
                                            logic [10:0] snap, logic prev_low,
                                            logic [10:0] prev_snap);
        logic strobe;
        strobe = !wr_l || !rd_l;
        return {!(!wr_l && !rd_l), !(strobe && cs_l), !(oe && !rd_l),
                !(strobe && prev_low && snap != prev_snap)};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("inv main", 32'(inv_bits(ym_cs_l, ym_wr_l, ym_rd_l, yd_oe,
                  {ym_cs_l, ym_a0, yd_oe, yd_out}, m_prev_low, m_prev_snap)), 32'hF);
            check("inv fast", 32'(inv_bits(f_cs_l, f_wr_l, f_rd_l, f_yd_oe,
                  {f_cs_l, f_a0, f_yd_oe, f_yd_out}, f_prev_low, f_prev_snap)), 32'hF);
        end
        m_prev_low  <= !ym_wr_l || !ym_rd_l;
        m_prev_snap <= {ym_cs_l, ym_a0, yd_oe, yd_out};
        f_prev_low  <= !f_wr_l || !f_rd_l;
        f_prev_snap <= {f_cs_l, f_a0, f_yd_oe, f_yd_out};
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs [6];
    req_t rq [12];
    int   gap [12];
    req_t w_a, r_a, w_b;
    logic [4:0] exp_fw [8];
    logic [2:0] exp_fr [3];
    int   tgt;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_rd = 1'b0; req_reg = 8'h00; req_data = 8'h00;
        f_valid = 1'b0; f_rd = 1'b0; f_reg = 8'h00; f_data = 8'h00;
        resp_lo = 8'h55; resp_hi = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        check("reset ctl", 32'({req_ready, busy, ym_cs_l, ym_a0, ym_wr_l, ym_rd_l, yd_oe, rd_valid}),
              32'(8'b10101100));
        check("reset data", 32'({yd_out, rd_data}), 32'h0000);
        check("reset fast", 32'({f_ready, f_cs_l, f_wr_l, f_rd_l, f_yd_oe}), 32'(5'b11110));
        rst = 1'b0;
        idle(1);

        // Table vectors: write 0x20/0x21, reads against the responder, more writes/reads.
        vecs[0] = '{req: '{1'b0, 8'h20, 8'h21}, lo: 8'h00, hi: 8'h00, busy: 9'd236, exp_rd: 8'h00};
        vecs[1] = '{req: '{1'b1, 8'h00, 8'h00}, lo: 8'h55, hi: 8'hAA, busy: 9'd6,   exp_rd: 8'h55};
        vecs[2] = '{req: '{1'b1, 8'h01, 8'h77}, lo: 8'h55, hi: 8'hAA, busy: 9'd6,   exp_rd: 8'hAA};
        vecs[3] = '{req: '{1'b0, 8'hB0, 8'h3F}, lo: 8'h00, hi: 8'h00, busy: 9'd236, exp_rd: 8'h00};
        vecs[4] = '{req: '{1'b1, 8'hFE, 8'h00}, lo: 8'h9C, hi: 8'h11, busy: 9'd6,   exp_rd: 8'h9C};
        vecs[5] = '{req: '{1'b1, 8'h03, 8'h00}, lo: 8'h9C, hi: 8'h42, busy: 9'd6,   exp_rd: 8'h42};
        for (int i = 0; i < 6; i++) begin
            resp_lo = vecs[i].lo;
            resp_hi = vecs[i].hi;
            run_txn(vecs[i].req, int'(vecs[i].busy), vecs[i].exp_rd, 1'b0, '0,
                    $sformatf("vec%0d", i));
            idle(2);
        end

        // req_valid held through a write, then back-to-back read, then read->write.
        resp_lo = 8'h55; resp_hi = 8'hAA;
        w_a = '{1'b0, 8'hA0, 8'h5A};
        r_a = '{1'b1, 8'h01, 8'h00};
        w_b = '{1'b0, 8'hBD, 8'hC0};
        run_txn(w_a, 236, 8'h00, 1'b1, r_a, "b2b write");
        run_txn(r_a, 6, 8'hAA, 1'b1, w_b, "b2b read");
        run_txn(w_b, 236, 8'h00, 1'b0, '0, "b2b write2");
        idle(1);

        // Reset in the middle of the data-phase write pulse.
        req_valid = 1'b1; req_rd = 1'b0; req_reg = 8'h40; req_data = 8'h3F;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tgt = S + P + H + AW + S + 2;
        for (int k = 1; k < tgt; k++) begin
            @(posedge clk); #1;
        end
        check("rst mid pulse", 32'({ym_wr_l, ym_cs_l, ym_a0, yd_oe, yd_out}),
              32'({1'b0, 1'b0, 1'b1, 1'b1, 8'h3F}));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst abort", 32'({ym_wr_l, ym_cs_l, yd_oe, req_ready, busy}), 32'(5'b11010));
        run_txn('{1'b0, 8'h41, 8'h12}, 236, 8'h00, 1'b0, '0, "after rst");
        idle(1);

        // All-ones timing instance: every state exactly one cycle.
        exp_fw = '{5'b00110, 5'b00010, 5'b00110, 5'b10100, 5'b01110, 5'b01010, 5'b01110, 5'b11100};
        f_valid = 1'b1; f_rd = 1'b0; f_reg = 8'h08; f_data = 8'h40;
        @(posedge clk); #1;
        f_valid = 1'b0; f_reg = 8'hFF; f_data = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            check($sformatf("fast w k=%0d", k + 1), 32'({f_cs_l, f_a0, f_wr_l, f_yd_oe, f_ready}),
                  32'(exp_fw[k]));
            if (k == 1) check("fast w addr", 32'(f_yd_out), 32'h08);
            if (k == 5) check("fast w data", 32'(f_yd_out), 32'h40);
        end
        @(posedge clk); #1;
        check("fast w done", 32'({f_ready, f_busy, f_cs_l}), 32'(3'b101));
        exp_fr = '{3'b010, 3'b000, 3'b010};
        f_valid = 1'b1; f_rd = 1'b1; f_reg = 8'h01;
        @(posedge clk); #1;
        f_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            check($sformatf("fast r k=%0d", k + 1), 32'({f_cs_l, f_rd_l, f_ready}), 32'(exp_fr[k]));
        end
        @(posedge clk); #1;
        check("fast r done", 32'({f_ready, f_rd_valid, f_rd_data}), 32'({2'b11, 8'hC3}));
        @(posedge clk); #1;
        check("fast r pulse", 32'(f_rd_valid), 32'd0);

        // Randomised traffic with random gaps; gap 0 means back-to-back.
        for (int i = 0; i < 12; i++) begin
            rq[i]  = '{1'($urandom), 8'($urandom), 8'($urandom)};
            gap[i] = $urandom_range(0, 3);
        end
        for (int i = 0; i < 12; i++) begin
            logic chain;
            resp_lo = 8'($urandom);
            resp_hi = 8'($urandom);
            chain = (gap[i] == 0) && (i < 11);
            run_txn(rq[i], busy_len(rq[i]), rq[i].reg_idx[0] ? resp_hi : resp_lo, chain,
                    (i < 11) ? rq[i + 1] : rq[i], $sformatf("rand%0d", i));
            if (!chain) idle(gap[i]);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
